// File: rtl/sdm_decimator.sv
// Second-order CIC decimator: 1-bit sigma-delta stream in, 8-bit saturated sample out every 2^OSR_LOG2 enabled cycles.
// Latency: 2-cycle input sync, registered output on the comb cycle; no backpressure, sample must be taken on its valid cycle.
module sdm_decimator #(
    parameter int OSR_LOG2 = 6
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ena,
    input  logic       din,
    output logic [7:0] sample,
    output logic       valid,
    output logic       sat
);

    localparam int W     = 2 * OSR_LOG2 + 1;
    localparam int SHIFT = 2 * OSR_LOG2 - 8;

    typedef enum logic {
        WARMUP = 1'b0,
        RUN    = 1'b1
    } state_e;

    logic                s1_q, s1_d;
    logic                s2_q, s2_d;
    logic                ena_q;
    logic [W-1:0]        i1_q, i1_d;
    logic [W-1:0]        i2_q, i2_d;
    logic [W-1:0]        d1_q, d1_d;
    logic [W-1:0]        d2_q, d2_d;
    logic [OSR_LOG2-1:0] ph_q, ph_d;
    logic [1:0]          win_q, win_d;
    state_e              state_q, state_d;
    logic [7:0]          sample_q, sample_d;
    logic                sat_q, sat_d;
    logic                valid_q, valid_d;

    logic                rise;
    logic                acc;
    logic                comb_upd;
    logic                emit;
    logic [W-1:0]        c1;
    logic [W-1:0]        y;
    logic [8:0]          scaled;

    assign rise     = ena & ~ena_q;
    assign acc      = ena & ~ena_q ? 1'b0 : ena;
    assign comb_upd = acc & (&ph_q);
    assign c1       = i2_q - d1_q;
    assign y        = c1 - d2_q;
    // Full scale 2^(W-1) shifted down leaves 9 bits; bit 8 only sets at exact full scale.
    assign scaled   = y[W-1:SHIFT];

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q     <= 1'b0;
            s2_q     <= 1'b0;
            ena_q    <= 1'b0;
            i1_q     <= '0;
            i2_q     <= '0;
            d1_q     <= '0;
            d2_q     <= '0;
            ph_q     <= '0;
            win_q    <= '0;
            state_q  <= WARMUP;
            sample_q <= '0;
            sat_q    <= 1'b0;
            valid_q  <= 1'b0;
        end else begin
            s1_q     <= s1_d;
            s2_q     <= s2_d;
            ena_q    <= ena;
            i1_q     <= i1_d;
            i2_q     <= i2_d;
            d1_q     <= d1_d;
            d2_q     <= d2_d;
            ph_q     <= ph_d;
            win_q    <= win_d;
            state_q  <= state_d;
            sample_q <= sample_d;
            sat_q    <= sat_d;
            valid_q  <= valid_d;
        end
    end

    // Datapath: synchronizer, integrators, comb delays and phase counter.
    always_comb begin
        s1_d = s1_q;
        s2_d = s2_q;
        i1_d = i1_q;
        i2_d = i2_q;
        d1_d = d1_q;
        d2_d = d2_q;
        ph_d = ph_q;
        if (ena) begin
            s1_d = din;
            s2_d = s1_q;
        end
        if (rise) begin
            i1_d = '0;
            i2_d = '0;
            d1_d = '0;
            d2_d = '0;
            ph_d = '0;
        end else if (acc) begin
            i1_d = i1_q + {{(W-1){1'b0}}, s2_q};
            i2_d = i2_q + i1_q;
            ph_d = ph_q + {{(OSR_LOG2-1){1'b0}}, 1'b1};
            if (comb_upd) begin
                d1_d = i2_q;
                d2_d = c1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        win_d   = win_q;
        if (rise) begin
            state_d = WARMUP;
            win_d   = '0;
        end else if (comb_upd && state_q == WARMUP) begin
            if (win_q == 2'd2) begin
                state_d = RUN;
            end else begin
                win_d = win_q + 2'd1;
            end
        end
    end

    always_comb begin
        emit     = comb_upd & ((state_q == RUN) | (win_q == 2'd2));
        valid_d  = emit;
        sample_d = sample_q;
        sat_d    = sat_q;
        if (emit) begin
            sat_d    = scaled[8];
            sample_d = scaled[8] ? 8'hFF : scaled[7:0];
        end
    end

    assign sample = sample_q;
    assign valid  = valid_q;
    assign sat    = sat_q;

endmodule

// File: tb/tb_sdm_decimator.sv
// Bench for sdm_decimator: directed scenarios plus random bitstreams against a triangular-kernel CIC2 model.
module tb_sdm_decimator;

    localparam int OSR_LOG2 = 6;
    localparam int R        = 1 << OSR_LOG2;
    localparam int SHIFT    = 2 * OSR_LOG2 - 8;
    localparam int FIRST    = 3 * R - 1;

    logic       clk;
    logic       rst;
    logic       ena;
    logic       din;
    logic [7:0] sample;
    logic       valid;
    logic       sat;

    int n_pass  = 0;
    int n_total = 0;

    // Reference model state
    bit         dh[$];
    bit         xs[$];
    int         acc_j;
    int         nupd;
    bit         m_prev_ena;
    logic [7:0] m_sample;
    logic       m_sat;
    logic       m_valid;

    // Stimulus mode for din: 0 hold, 1 alternate, 2 one-in-four, 3 random
    int         mode;
    int         pat_ph;

    sdm_decimator #(.OSR_LOG2(OSR_LOG2)) dut (
        .clk    (clk),
        .rst    (rst),
        .ena    (ena),
        .din    (din),
        .sample (sample),
        .valid  (valid),
        .sat    (sat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    // Decimated value of a window ending at accepted cycle J: triangular weights over the last 2R inputs.
    function automatic int calc_y(input int J);
        int y;
        int w;
        y = 0;
        for (int t = 1; t <= 2 * R; t++) begin
            w = (t <= R) ? (t - 1) : (2 * R + 1 - t);
            y += w * int'(xs[J - t]);
        end
        return y;
    endfunction

    task automatic model_edge();
        int  y;
        int  q;
        bit  x;
        m_valid = 1'b0;
        if (rst) begin
            dh.delete();
            dh.push_back(1'b0);
            dh.push_back(1'b0);
            xs.delete();
            acc_j      = 0;
            nupd       = 0;
            m_prev_ena = 1'b0;
            m_sample   = 8'd0;
            m_sat      = 1'b0;
            return;
        end
        if (ena && !m_prev_ena) begin
            xs.delete();
            acc_j = 0;
            nupd  = 0;
            dh.push_back(din);
        end else if (ena) begin
            x = dh[$-1];
            xs.push_back(x);
            if (acc_j % R == R - 1) begin
                nupd++;
                if (nupd >= 3) begin
                    y        = calc_y(acc_j);
                    q        = y >> SHIFT;
                    m_valid  = 1'b1;
                    m_sat    = (q >= 256);
                    m_sample = (q >= 256) ? 8'd255 : q[7:0];
                end
            end
            acc_j++;
            dh.push_back(din);
        end
        while (dh.size() > 4) void'(dh.pop_front());
        m_prev_ena = ena;
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
        chk("valid", {31'd0, valid}, {31'd0, m_valid});
        chk("sample", {24'd0, sample}, {24'd0, m_sample});
        chk("sat", {31'd0, sat}, {31'd0, m_sat});
        pat_ph++;
        case (mode)
            1:       din = pat_ph[0];
            2:       din = (pat_ph % 4 == 0);
            3:       din = 1'($urandom() % 2);
            default: din = din;
        endcase
    endtask

    // Runs until the DUT strobes; returns ticks taken and the accepted-cycle index of the strobe.
    task automatic wait_valid(input string tag, input int max, output int ticks, output int idx);
        ticks = 0;
        do begin
            tick();
            ticks++;
        end while (!valid && ticks < max);
        idx = acc_j - 1;
        if (!valid) chk({tag, "_timeout"}, {31'd0, valid}, 32'd1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        int ticks;
        int idx;
        rst    = 1'b1;
        ena    = 1'b0;
        din    = 1'b0;
        mode   = 0;
        pat_ph = 0;
        m_prev_ena = 1'b0;
        tick();
        tick();
        chk("reset_sample", {24'd0, sample}, 32'd0);
        chk("reset_valid", {31'd0, valid}, 32'd0);
        chk("reset_sat", {31'd0, sat}, 32'd0);

        // All ones: full scale clips
        din = 1'b1;
        ena = 1'b1;
        do_reset();
        wait_valid("ones_first", 400, ticks, idx);
        chk("ones_first_idx", idx, FIRST);
        chk("ones_sample", {24'd0, sample}, 32'd255);
        chk("ones_sat", {31'd0, sat}, 32'd1);
        for (int k = 0; k < 3; k++) begin
            wait_valid("ones_next", 2 * R, ticks, idx);
            chk("ones_spacing", ticks, R);
            chk("ones_sample_run", {24'd0, sample}, 32'd255);
            chk("ones_sat_run", {31'd0, sat}, 32'd1);
        end

        // ena gap mid-window with din held high
        for (int k = 0; k < 20; k++) tick();
        ena = 1'b0;
        for (int k = 0; k < 10; k++) begin
            tick();
            chk("gap_valid", {31'd0, valid}, 32'd0);
            chk("gap_sample", {24'd0, sample}, 32'd255);
            chk("gap_sat", {31'd0, sat}, 32'd1);
        end
        ena = 1'b1;
        wait_valid("gap_restart", 400, ticks, idx);
        chk("gap_restart_idx", idx, FIRST);
        chk("gap_restart_ticks", ticks, FIRST + 2);
        chk("gap_restart_sample", {24'd0, sample}, 32'd255);

        // All zeros
        din = 1'b0;
        do_reset();
        wait_valid("zeros_first", 400, ticks, idx);
        chk("zeros_first_idx", idx, FIRST);
        for (int k = 0; k < 3; k++) begin
            wait_valid("zeros_next", 2 * R, ticks, idx);
            chk("zeros_spacing", ticks, R);
            chk("zeros_sample", {24'd0, sample}, 32'd0);
            chk("zeros_sat", {31'd0, sat}, 32'd0);
        end

        // Alternating 1,0: half scale
        mode = 1;
        do_reset();
        wait_valid("alt_first", 400, ticks, idx);
        for (int k = 0; k < 3; k++) begin
            wait_valid("alt_next", 2 * R, ticks, idx);
            chk("alt_sample", {24'd0, sample}, 32'd128);
            chk("alt_sat", {31'd0, sat}, 32'd0);
        end

        // Reset pulse mid-operation
        for (int k = 0; k < 17; k++) tick();
        rst = 1'b1;
        tick();
        chk("midrst_sample", {24'd0, sample}, 32'd0);
        chk("midrst_valid", {31'd0, valid}, 32'd0);
        chk("midrst_sat", {31'd0, sat}, 32'd0);
        rst = 1'b0;
        wait_valid("midrst_first", 400, ticks, idx);
        chk("midrst_first_idx", idx, FIRST);
        chk("midrst_first_ticks", ticks, FIRST + 2);

        // Density 1/4
        mode = 2;
        do_reset();
        wait_valid("quarter_first", 400, ticks, idx);
        for (int k = 0; k < 3; k++) begin
            wait_valid("quarter_next", 2 * R, ticks, idx);
            chk("quarter_sample", {24'd0, sample}, 32'd64);
        end

        // Random bitstream, every cycle checked against the model
        mode = 3;
        do_reset();
        wait_valid("rand_first", 400, ticks, idx);
        for (int k = 0; k < 8; k++) begin
            wait_valid("rand_next", 2 * R, ticks, idx);
            chk("rand_spacing", ticks, R);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
